// File: rtl/idle_sync_lanes.sv
// Multi-lane COMMA synchroniser / IDLE detector: per-lane ACQ/SYNC FSM, data forwarding, saturating error counts.
// Latency 1 cycle from the sampling edge; no backpressure, in_valid=0 simply holds lane state.
module idle_sync_lanes #(
    parameter int               LANES    = 4,
    parameter int               SYM_W    = 8,
    parameter logic [SYM_W-1:0] COMMA    = 8'hBC,
    parameter logic [SYM_W-1:0] IDLE_SYM = 8'h7C,
    parameter int               SYNC_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               ERR_W    = 8
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [LANES*SYM_W-1:0] sym_in,
    input  logic [LANES-1:0]       sym_err,
    input  logic                   clr_cnt,
    output logic [LANES-1:0]       sync_ok,
    output logic                   all_sync,
    output logic [LANES-1:0]       idle_out,
    output logic                   all_idle,
    output logic [LANES*SYM_W-1:0] data_out,
    output logic [LANES-1:0]       data_valid,
    output logic [LANES*ERR_W-1:0] err_cnt
);

    localparam int CW = $clog2(SYNC_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    typedef enum logic {
        ACQ  = 1'b0,
        SYNC = 1'b1
    } lane_state_e;

    lane_state_e            state_q     [LANES];
    lane_state_e            state_d     [LANES];
    logic [CW-1:0]          comma_cnt_q [LANES];
    logic [CW-1:0]          comma_cnt_d [LANES];
    logic [BW-1:0]          bad_cnt_q   [LANES];
    logic [BW-1:0]          bad_cnt_d   [LANES];
    logic [ERR_W-1:0]       err_cnt_q   [LANES];
    logic [ERR_W-1:0]       err_cnt_d   [LANES];
    logic [LANES-1:0]       idle_q, idle_d;
    logic [LANES-1:0]       dvld_q, dvld_d;
    logic [LANES*SYM_W-1:0] data_q, data_d;
    logic                   all_sync_q, all_sync_d;
    logic                   all_idle_q, all_idle_d;
    logic [LANES-1:0]       sync_d;

    logic [LANES-1:0]       is_err, is_comma, is_idle, is_data;

    // An errored symbol belongs to no other class, whatever its value.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign is_err[g]   = sym_err[g];
        assign is_comma[g] = !sym_err[g] && (sym_in[g*SYM_W +: SYM_W] == COMMA);
        assign is_idle[g]  = !sym_err[g] && (sym_in[g*SYM_W +: SYM_W] == IDLE_SYM);
        assign is_data[g]  = !sym_err[g] && !is_comma[g] && !is_idle[g];

        assign sync_ok[g]                 = (state_q[g] == SYNC);
        assign err_cnt[g*ERR_W +: ERR_W]  = err_cnt_q[g];
    end

    always_comb begin
        data_d = in_valid ? sym_in : data_q;
        idle_d = '0;
        dvld_d = '0;
        sync_d = '0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i]     = state_q[i];
            comma_cnt_d[i] = comma_cnt_q[i];
            bad_cnt_d[i]   = bad_cnt_q[i];
            err_cnt_d[i]   = err_cnt_q[i];

            if (in_valid) begin
                if (state_q[i] == SYNC) begin
                    idle_d[i] = is_idle[i];
                    dvld_d[i] = is_data[i];
                    if (is_err[i]) begin
                        if (err_cnt_q[i] != '1) begin
                            err_cnt_d[i] = err_cnt_q[i] + ERR_W'(1);
                        end
                        if (bad_cnt_q[i] == BW'(LOSS_CNT - 1)) begin
                            state_d[i]     = ACQ;
                            bad_cnt_d[i]   = '0;
                            comma_cnt_d[i] = '0;
                        end else begin
                            bad_cnt_d[i] = bad_cnt_q[i] + BW'(1);
                        end
                    end else begin
                        bad_cnt_d[i] = '0;
                    end
                end else begin
                    if (is_comma[i]) begin
                        if (comma_cnt_q[i] == CW'(SYNC_CNT - 1)) begin
                            state_d[i]     = SYNC;
                            comma_cnt_d[i] = '0;
                        end else begin
                            comma_cnt_d[i] = comma_cnt_q[i] + CW'(1);
                        end
                    end else begin
                        comma_cnt_d[i] = '0;
                    end
                end
            end

            // Clear beats a same-cycle increment.
            if (clr_cnt) begin
                err_cnt_d[i] = '0;
            end
            sync_d[i] = (state_d[i] == SYNC);
        end
        all_sync_d = &sync_d;
        all_idle_d = &idle_d;
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i]     <= ACQ;
                comma_cnt_q[i] <= '0;
                bad_cnt_q[i]   <= '0;
                err_cnt_q[i]   <= '0;
            end
            idle_q     <= '0;
            dvld_q     <= '0;
            data_q     <= '0;
            all_sync_q <= 1'b0;
            all_idle_q <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i]     <= state_d[i];
                comma_cnt_q[i] <= comma_cnt_d[i];
                bad_cnt_q[i]   <= bad_cnt_d[i];
                err_cnt_q[i]   <= err_cnt_d[i];
            end
            idle_q     <= idle_d;
            dvld_q     <= dvld_d;
            data_q     <= data_d;
            all_sync_q <= all_sync_d;
            all_idle_q <= all_idle_d;
        end
    end

    assign idle_out   = idle_q;
    assign data_valid = dvld_q;
    assign data_out   = data_q;
    assign all_sync   = all_sync_q;
    assign all_idle   = all_idle_q;

endmodule

// File: tb/tb_idle_sync_lanes.sv
// Bench for idle_sync_lanes: directed vector table, then randomized traffic against a lane model.
module tb_idle_sync_lanes;

    localparam int L = 4;
    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_IDLE  = 8'h7C;
    localparam int N_SYNC = 4;
    localparam int N_LOSS = 3;

    logic          clk = 1'b0;
    logic          reset, in_valid, clr_cnt;
    logic [31:0]   sym_in;
    logic [3:0]    sym_err;

    logic [3:0]    sync_ok_a, idle_out_a, data_valid_a;
    logic          all_sync_a, all_idle_a;
    logic [31:0]   data_out_a, err_cnt_a;
    logic [3:0]    sync_ok_b, idle_out_b, data_valid_b;
    logic          all_sync_b, all_idle_b;
    logic [31:0]   data_out_b;
    logic [7:0]    err_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idle_sync_lanes dut_a (
        .clk_32f(clk), .reset(reset), .in_valid(in_valid), .sym_in(sym_in),
        .sym_err(sym_err), .clr_cnt(clr_cnt), .sync_ok(sync_ok_a), .all_sync(all_sync_a),
        .idle_out(idle_out_a), .all_idle(all_idle_a), .data_out(data_out_a),
        .data_valid(data_valid_a), .err_cnt(err_cnt_a)
    );

    idle_sync_lanes #(.ERR_W(2)) dut_b (
        .clk_32f(clk), .reset(reset), .in_valid(in_valid), .sym_in(sym_in),
        .sym_err(sym_err), .clr_cnt(clr_cnt), .sync_ok(sync_ok_b), .all_sync(all_sync_b),
        .idle_out(idle_out_b), .all_idle(all_idle_b), .data_out(data_out_b),
        .data_valid(data_valid_b), .err_cnt(err_cnt_b)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] sym;
        logic [3:0]  err;
        logic        clr;
        logic [3:0]  e_sync;
        logic [3:0]  e_idle;
        logic [3:0]  e_dv;
        logic [7:0]  e_err0;
        logic [1:0]  e_errb0;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic vld, input logic [31:0] sym,
                       input logic [3:0] err, input logic clr, input logic [3:0] e_sync,
                       input logic [3:0] e_idle, input logic [3:0] e_dv,
                       input logic [7:0] e_err0, input logic [1:0] e_errb0);
        vec_t v;
        v.rst = rst; v.vld = vld; v.sym = sym; v.err = err; v.clr = clr;
        v.e_sync = e_sync; v.e_idle = e_idle; v.e_dv = e_dv;
        v.e_err0 = e_err0; v.e_errb0 = e_errb0;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic vld, input logic [31:0] sym,
                         input logic [3:0] err, input logic clr);
        reset = rst; in_valid = vld; sym_in = sym; sym_err = err; clr_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    // Reference: each lane tracks "locked?" plus lengths of the current comma / error runs.
    bit          m_locked [L];
    int          m_comma_run [L];
    int          m_err_run [L];
    int          m_errs_a [L];
    int          m_errs_b [L];
    logic [3:0]  m_idle, m_dv;
    logic [31:0] m_data;

    task automatic model_step(input logic rst, input logic vld, input logic [31:0] sym,
                              input logic [3:0] err, input logic clr);
        m_idle = '0;
        m_dv   = '0;
        if (rst) begin
            m_data = '0;
            for (int i = 0; i < L; i++) begin
                m_locked[i] = 0; m_comma_run[i] = 0; m_err_run[i] = 0;
                m_errs_a[i] = 0; m_errs_b[i] = 0;
            end
            return;
        end
        if (vld) m_data = sym;
        for (int i = 0; i < L; i++) begin
            logic [7:0] s;
            s = sym[i*8 +: 8];
            if (vld) begin
                if (m_locked[i]) begin
                    if (err[i]) begin
                        m_errs_a[i] = (m_errs_a[i] + 1 > 255) ? 255 : m_errs_a[i] + 1;
                        m_errs_b[i] = (m_errs_b[i] + 1 > 3) ? 3 : m_errs_b[i] + 1;
                        m_err_run[i]++;
                        if (m_err_run[i] == N_LOSS) begin
                            m_locked[i] = 0; m_err_run[i] = 0; m_comma_run[i] = 0;
                        end
                    end else begin
                        m_err_run[i] = 0;
                        if (s == K_IDLE) m_idle[i] = 1'b1;
                        else if (s != K_COMMA) m_dv[i] = 1'b1;
                    end
                end else if (!err[i] && s == K_COMMA) begin
                    m_comma_run[i]++;
                    if (m_comma_run[i] == N_SYNC) begin
                        m_locked[i] = 1; m_comma_run[i] = 0;
                    end
                end else begin
                    m_comma_run[i] = 0;
                end
            end
            if (clr) begin
                m_errs_a[i] = 0; m_errs_b[i] = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] exp_data;
        logic [3:0]  m_sync;
        logic [31:0] m_erra_v;
        logic [7:0]  m_errb_v;
        int          err_pct;

        reset = 1'b1; in_valid = 1'b0; sym_in = '0; sym_err = '0; clr_cnt = 1'b0;

        //   rst vld sym           err   clr sync   idle   dv     err0 errb0
        add(1, 0, 32'h0,         4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 32'h000000BC, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        add(0, 1, 32'h000000BC,  4'h0, 0, 4'h1, 4'h0, 4'h0, 0, 0);
        add(1, 0, 32'h0,         4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 32'h000000BC, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        add(0, 1, 32'h0000007C,  4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 32'h000000BC, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        add(0, 1, 32'h000000BC,  4'h0, 0, 4'h1, 4'h0, 4'h0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 32'hBCBCBCBC, 4'h0, 0, 4'h1, 4'h0, 4'h0, 0, 0);
        add(0, 1, 32'hBCBCBCBC,  4'h0, 0, 4'hF, 4'h0, 4'h0, 0, 0);
        add(0, 1, 32'h7C7C7C7C,  4'h0, 0, 4'hF, 4'hF, 4'h0, 0, 0);
        add(0, 1, 32'hAAAAAAAA,  4'h0, 0, 4'hF, 4'h0, 4'hF, 0, 0);
        add(0, 1, 32'hAAAAAAAA,  4'h1, 0, 4'hF, 4'h0, 4'hE, 1, 1);
        add(0, 1, 32'hAAAAAAAA,  4'h0, 0, 4'hF, 4'h0, 4'hF, 1, 1);
        add(0, 1, 32'hAAAAAAAA,  4'h1, 0, 4'hF, 4'h0, 4'hE, 2, 2);
        add(0, 1, 32'hAAAAAAAA,  4'h1, 0, 4'hF, 4'h0, 4'hE, 3, 3);
        add(0, 1, 32'hAAAAAAAA,  4'h1, 0, 4'hE, 4'h0, 4'hE, 4, 3);
        add(0, 1, 32'hBCBCBCBC,  4'h0, 0, 4'hE, 4'h0, 4'h0, 4, 3);
        add(0, 1, 32'hBCBCBCBC,  4'h0, 0, 4'hE, 4'h0, 4'h0, 4, 3);
        for (int k = 0; k < 5; k++)
            add(0, 0, 32'h55555555, 4'hF, 0, 4'hE, 4'h0, 4'h0, 4, 3);
        add(0, 1, 32'hBCBCBCBC,  4'h0, 0, 4'hE, 4'h0, 4'h0, 4, 3);
        add(0, 1, 32'hBCBCBCBC,  4'h0, 0, 4'hF, 4'h0, 4'h0, 4, 3);
        add(0, 1, 32'h7C7C7C7C,  4'h1, 1, 4'hF, 4'hE, 4'h0, 0, 0);
        add(0, 1, 32'h7C7C7C7C,  4'h0, 0, 4'hF, 4'hF, 4'h0, 0, 0);
        add(1, 1, 32'h7C7C7C7C,  4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        for (int k = 0; k < 3; k++)
            add(0, 1, 32'hBCBCBCBC, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
        add(0, 1, 32'hBCBCBCBC,  4'h0, 0, 4'hF, 4'h0, 4'h0, 0, 0);
        add(0, 1, 32'h7C7C7C7C,  4'h0, 0, 4'hF, 4'hF, 4'h0, 0, 0);

        exp_data = '0;
        for (int k = 0; k < tbl.size(); k++) begin
            vec_t v;
            v = tbl[k];
            apply(v.rst, v.vld, v.sym, v.err, v.clr);
            if (v.rst) exp_data = '0;
            else if (v.vld) exp_data = v.sym;
            chk($sformatf("t%0d sync_ok", k),    sync_ok_a,    v.e_sync);
            chk($sformatf("t%0d all_sync", k),   all_sync_a,   &v.e_sync);
            chk($sformatf("t%0d idle_out", k),   idle_out_a,   v.e_idle);
            chk($sformatf("t%0d all_idle", k),   all_idle_a,   &v.e_idle);
            chk($sformatf("t%0d data_valid", k), data_valid_a, v.e_dv);
            chk($sformatf("t%0d data_out", k),   data_out_a,   exp_data);
            chk($sformatf("t%0d err_cnt", k),    err_cnt_a,    {24'h0, v.e_err0});
            chk($sformatf("t%0d err_cnt_w2", k), err_cnt_b,    {6'h0, v.e_errb0});
        end

        // Randomized traffic: alternate quiet and error-heavy epochs so lanes both lock and drop.
        model_step(1'b1, 1'b0, '0, '0, 1'b0);
        apply(1'b1, 1'b0, '0, '0, 1'b0);
        err_pct = 2;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_vld, r_clr;
            logic [31:0] r_sym;
            logic [3:0]  r_err;
            if (c % 250 == 0) err_pct = (err_pct == 2) ? 40 : 2;
            r_rst = ($urandom_range(0, 399) == 0);
            r_vld = ($urandom_range(0, 99) < 90);
            r_clr = ($urandom_range(0, 99) < 3);
            for (int i = 0; i < L; i++) begin
                int p;
                p = $urandom_range(0, 99);
                if (p < 45)      r_sym[i*8 +: 8] = K_COMMA;
                else if (p < 60) r_sym[i*8 +: 8] = K_IDLE;
                else             r_sym[i*8 +: 8] = 8'($urandom_range(0, 255));
                r_err[i] = ($urandom_range(0, 99) < err_pct);
            end
            apply(r_rst, r_vld, r_sym, r_err, r_clr);
            model_step(r_rst, r_vld, r_sym, r_err, r_clr);
            for (int i = 0; i < L; i++) begin
                m_sync[i]          = m_locked[i];
                m_erra_v[i*8 +: 8] = 8'(m_errs_a[i]);
                m_errb_v[i*2 +: 2] = 2'(m_errs_b[i]);
            end
            chk($sformatf("r%0d sync_ok", c),    sync_ok_a,    m_sync);
            chk($sformatf("r%0d all_sync", c),   all_sync_a,   &m_sync);
            chk($sformatf("r%0d idle_out", c),   idle_out_a,   m_idle);
            chk($sformatf("r%0d all_idle", c),   all_idle_a,   &m_idle);
            chk($sformatf("r%0d data_valid", c), data_valid_a, m_dv);
            chk($sformatf("r%0d data_out", c),   data_out_a,   m_data);
            chk($sformatf("r%0d err_cnt", c),    err_cnt_a,    m_erra_v);
            chk($sformatf("r%0d err_cnt_w2", c), err_cnt_b,    m_errb_v);
            chk($sformatf("r%0d sync_ok_w2", c), sync_ok_b,    m_sync);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
